tanh_layer_sequencer16: RTL and testbench

Sequencer that streams a flattened vector of N half-precision (IEEE-754 binary16) values through one iterative tanh core and assembles the activated vector. It sits between a convolution/pooling output register and the next layer's input. For each element it drives the core's per-element init pulse, holds the operand stable, waits for the core's finished flag, and captures the result. A watchdog prevents a stalled core from hanging the layer.

---
 rtl/tanh_layer_sequencer16.sv | 111 +++++++++++
 tb/tb_tanh_layer_sequencer16.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/tanh_layer_sequencer16.sv
// tanh_layer_sequencer16: streams N binary16 elements through one iterative tanh
// core, capturing each result (or qNaN on a watchdog expiry) into out_vec.
`default_nettype none

module tanh_layer_sequencer16 #(
  parameter int DATA_WIDTH = 16,
  parameter int N          = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [N*DATA_WIDTH-1:0] in_vec,
  output logic [DATA_WIDTH-1:0]   core_x,
  output logic                    core_init,
  input  logic [DATA_WIDTH-1:0]   core_out,
  input  logic                    core_finished,
  output logic [N*DATA_WIDTH-1:0] out_vec,
  output logic                    busy,
  output logic                    done,
  output logic                    timeout_err
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_INIT = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [IW-1:0]         LAST_IDX = IW'(N - 1);
  localparam logic [WW-1:0]         LAST_WD  = WW'(TIMEOUT - 1);
  localparam logic [DATA_WIDTH-1:0] QNAN     = DATA_WIDTH'(16'h7E00);

  logic [1:0]                       state_q, state_d;
  logic [IW-1:0]                    idx_q, idx_d;
  logic [WW-1:0]                    wd_q, wd_d;
  logic [N-1:0][DATA_WIDTH-1:0]     vec_q, vec_d;
  logic [N-1:0][DATA_WIDTH-1:0]     out_q, out_d;
  logic                             terr_q, terr_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      wd_q    <= '0;
      vec_q   <= '0;
      out_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wd_q    <= wd_d;
      vec_q   <= vec_d;
      out_q   <= out_d;
      terr_q  <= terr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wd_d    = wd_q;
    vec_d   = vec_q;
    out_d   = out_q;
    terr_d  = terr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          vec_d   = in_vec;
          idx_d   = '0;
          wd_d    = '0;
          terr_d  = 1'b0;
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        wd_d    = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        // A result arriving on the last watchdog cycle still wins over the timeout.
        if (core_finished || (wd_q == LAST_WD)) begin
          out_d[idx_q] = core_finished ? core_out : QNAN;
          if (!core_finished) terr_d = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = S_INIT;
          end
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign core_x      = ((state_q == S_INIT) || (state_q == S_RUN)) ? vec_q[idx_q] : '0;
  assign core_init   = (state_q == S_INIT);
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign out_vec     = out_q;
  assign timeout_err = terr_q;

endmodule

`default_nettype wire

// File: tb/tb_tanh_layer_sequencer16.sv
// Bench for tanh_layer_sequencer16: behavioural tanh core stub plus a done-driven scoreboard.
`default_nettype none

module tb_tanh_layer_sequencer16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [63:0] in_vec = '0;
  logic [15:0] core_x;
  logic        core_init;
  logic [15:0] core_out;
  logic        core_finished;
  logic [63:0] out_vec;
  logic        busy, done, timeout_err;

  tanh_layer_sequencer16 #(.DATA_WIDTH(16), .N(4), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .start(start), .in_vec(in_vec),
    .core_x(core_x), .core_init(core_init), .core_out(core_out),
    .core_finished(core_finished), .out_vec(out_vec), .busy(busy),
    .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Core stub: saturating inputs finish one cycle after init, others after four;
  // the finished flag stays high (stale) until the next init edge.
  logic [15:0] c_x, c_out;
  logic        c_fin;
  int          c_cnt;
  logic        stall_en = 1'b0;
  assign core_out      = c_out;
  assign core_finished = c_fin;

  function automatic logic [15:0] taylor(input logic [15:0] x);
    case (x)
      16'h0000: return 16'h0000;
      16'h3400: return 16'h33D6;
      16'hB400: return 16'hB3D6;
      16'h3000: return 16'h2FF5;
      default:  return x ^ 16'h00FF;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_fin <= 1'b0; c_cnt <= 0; c_out <= '0; c_x <= '0;
    end else if (core_init) begin
      c_x <= core_x;
      if (core_x[14:0] >= 15'h3E48) begin
        c_fin <= 1'b1; c_cnt <= 0;
        c_out <= core_x[15] ? 16'hBC00 : 16'h3C00;
      end else begin
        c_fin <= 1'b0; c_cnt <= 1;
      end
    end else if (!c_fin && c_cnt != 0 && !(stall_en && c_x == 16'h3800)) begin
      if (c_cnt == 3) begin
        c_fin <= 1'b1; c_out <= taylor(c_x); c_cnt <= 0;
      end else begin
        c_cnt <= c_cnt + 1;
      end
    end
  end

  typedef struct {
    logic [63:0] ov;
    logic        terr;
    int          lat;
    int          t0;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int init_cnt = 0;
  logic [15:0] held_x = '0;
  bit in_run = 0;

  function automatic logic [63:0] pk(input logic [15:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  // Monitor: core_x stability after each init, and full result check on done.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (core_init) begin
          init_cnt++; held_x = core_x; in_run = 1;
        end else if (in_run && busy && !done) begin
          checks++;
          if (core_x !== held_x) begin
            errors++;
            $display("FAIL core_x_stable: got %h want %h", core_x, held_x);
          end
        end
        if (done) begin
          in_run = 0;
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: done pulsed with no vector outstanding");
          end else begin
            e = sb.pop_front();
            if (out_vec !== e.ov) begin
              errors++;
              $display("FAIL out_vec: got %h want %h", out_vec, e.ov);
            end
            checks++;
            if (timeout_err !== e.terr) begin
              errors++;
              $display("FAIL timeout_err: got %b want %b", timeout_err, e.terr);
            end
            checks++;
            if (cyc - e.t0 != e.lat) begin
              errors++;
              $display("FAIL latency: got %0d want %0d", cyc - e.t0, e.lat);
            end
            checks++;
            if (init_cnt != 4) begin
              errors++;
              $display("FAIL init_pulses: got %0d want 4", init_cnt);
            end
          end
          init_cnt = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 200) begin
      @(negedge clk); n++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: done got 0 want 1 within 200 cycles", name);
      sb.delete();
    end
  endtask

  task automatic run_vec(input string name, input logic [63:0] iv, input logic [63:0] ov,
                         input logic terr, input int lat, input bit mid_start);
    @(negedge clk);
    in_vec = iv; start = 1'b1;
    sb.push_back('{ov, terr, lat, cyc});
    @(negedge clk);
    start = 1'b0; in_vec = '1;
    chk({name, "_busy"}, {63'd0, busy}, 64'd1);
    chk({name, "_terr_clear"}, {63'd0, timeout_err}, 64'd0);
    if (mid_start) begin
      repeat (3) @(negedge clk);
      in_vec = pk(16'h4000, 16'h4000, 16'h4000, 16'h4000); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(name);
  endtask

  initial begin
    #1;
    chk("rst_core_x", {48'd0, core_x}, 64'd0);
    chk("rst_core_init", {63'd0, core_init}, 64'd0);
    chk("rst_out_vec", out_vec, 64'd0);
    chk("rst_busy_done_terr", {61'd0, busy, done, timeout_err}, 64'd0);
    #20 reset = 1'b1;

    run_vec("taylor", pk(16'h0000, 16'h3400, 16'hB400, 16'h3000),
            pk(16'h0000, 16'h33D6, 16'hB3D6, 16'h2FF5), 1'b0, 21, 0);
    run_vec("saturate", pk(16'h4000, 16'hC000, 16'h4200, 16'hBE48),
            pk(16'h3C00, 16'hBC00, 16'h3C00, 16'hBC00), 1'b0, 9, 0);
    run_vec("stale", pk(16'h4000, 16'h3400, 16'h4000, 16'h3400),
            pk(16'h3C00, 16'h33D6, 16'h3C00, 16'h33D6), 1'b0, 15, 0);
    stall_en = 1'b1;
    run_vec("watchdog", pk(16'h3400, 16'h4000, 16'h3800, 16'hB400),
            pk(16'h33D6, 16'h3C00, 16'h7E00, 16'hB3D6), 1'b1, 29, 0);
    stall_en = 1'b0;
    run_vec("after_wd", pk(16'h0000, 16'h3400, 16'hB400, 16'h3000),
            pk(16'h0000, 16'h33D6, 16'hB3D6, 16'h2FF5), 1'b0, 21, 0);
    run_vec("mid_start", pk(16'h3000, 16'hB400, 16'h3400, 16'h0000),
            pk(16'h2FF5, 16'hB3D6, 16'h33D6, 16'h0000), 1'b0, 21, 1);

    // Reset while element 1 is in RUN.
    begin
      int n = 0;
      @(negedge clk);
      in_vec = pk(16'h3400, 16'h3400, 16'h3400, 16'h3400); start = 1'b1;
      sb.push_back('{64'd0, 1'b0, 0, cyc});
      @(negedge clk);
      start = 1'b0;
      while (init_cnt < 2 && n < 50) begin
        @(negedge clk); n++;
      end
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      sb.delete(); init_cnt = 0; in_run = 0;
      chk("mid_rst_core_x", {48'd0, core_x}, 64'd0);
      chk("mid_rst_out_vec", out_vec, 64'd0);
      chk("mid_rst_ctrl", {60'd0, core_init, busy, done, timeout_err}, 64'd0);
      repeat (2) @(negedge clk);
      chk("mid_rst_done_low", {63'd0, done}, 64'd0);
      #2 reset = 1'b1;
    end

    run_vec("post_reset", pk(16'h4000, 16'hC000, 16'h4200, 16'hBE48),
            pk(16'h3C00, 16'hBC00, 16'h3C00, 16'hBC00), 1'b0, 9, 0);
    repeat (5) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
